vga_timing_gen: RTL

Parametrised VGA raster timing generator; next generation of the fixed 640x480 sync block. Produces horizontal and vertical sync, the pixel coordinate, an active-video flag and line/frame boundary strobes for any mode described by four porch/sync/active numbers per axis, with selectable sync polarity and a synchronous restart. Sits between the pixel-rate tick generator and the game renderer/colour mux.

---
 rtl/vga_timing_pkg.sv | 32 +++
 rtl/vga_axis_counter.sv | 56 +++++
 rtl/vga_timing_gen.sv | 81 ++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and decode helper for the raster timing generator.
// Default mode is 640x480@60 (negative syncs); an 800x600@60 set is provided.
package vga_timing_pkg;

  // 640x480@60, 25.175 MHz pixel rate
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam int VGA640_POL      = 0;

  // 800x600@60, 40 MHz pixel rate, positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam int SVGA800_POL      = 1;

  // True when v lies in [lo, lo+len)
  function automatic logic in_window(int v, int lo, int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: modulo counter with enable and clear, terminal-count flag,
// registered sync decode and next-state active decode. Decodes are taken from
// the next-state count so registered outputs line up with the count register.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter int POL    = 0,
  parameter int W      = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc,
  output logic         o_sync,
  output logic         o_nxt_active
);

  localparam int   TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic L_POL = (POL != 0);

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_nxt;
  logic         r_sync;

  assign o_tc         = (r_cnt == W'(TOTAL - 1));
  assign o_cnt        = r_cnt;
  assign o_sync       = r_sync;
  assign o_nxt_active = (int'(w_nxt) < ACTIVE);

  // Next count: clear wins over wrap, wrap wins over increment
  always_comb begin
    w_nxt = r_cnt;
    if (i_en) begin
      if (i_clr || o_tc) w_nxt = '0;
      else               w_nxt = r_cnt + 1'b1;
    end
  end

  // Count and sync level register, both loaded from the next-state count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_sync <= ~L_POL;
    end else begin
      r_cnt  <= w_nxt;
      r_sync <= in_window(int'(w_nxt), ACTIVE + FP, SYNC) ? L_POL : ~L_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: hsync/vsync, pixel coordinate,
// active-video flag and line/frame end strobes for an arbitrary mode.
// Optional completed-frame counter enabled by VGA_TIMING_FRAME_COUNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = VGA640_H_ACTIVE,
  parameter int H_FP        = VGA640_H_FP,
  parameter int H_SYNC      = VGA640_H_SYNC,
  parameter int H_BP        = VGA640_H_BP,
  parameter int V_ACTIVE    = VGA640_V_ACTIVE,
  parameter int V_FP        = VGA640_V_FP,
  parameter int V_SYNC      = VGA640_V_SYNC,
  parameter int V_BP        = VGA640_V_BP,
  parameter int H_POL       = VGA640_POL,
  parameter int V_POL       = VGA640_POL,
  parameter int FRAME_CNT_W = 16,
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int X_W        = $clog2(H_TOTAL),
  localparam int Y_W        = $clog2(V_TOTAL)
) (
  input  logic                   inputclock,
  input  logic                   input_reset,
  input  logic                   pixel,
  input  logic                   input_restart,
  output logic                   output_hsync,
  output logic                   output_vsync,
  output logic [X_W-1:0]         output_x,
  output logic [Y_W-1:0]         output_y,
  output logic                   output_active,
  output logic                   output_line_end,
  output logic                   output_frame_end,
  output logic [FRAME_CNT_W-1:0] output_frame_count
);

  logic w_h_tc, w_v_tc, w_h_nxt_act, w_v_nxt_act, w_v_en;
  logic r_active;

  // Vertical steps on horizontal wrap, or clears with the horizontal on restart
  assign w_v_en = pixel & (w_h_tc | input_restart);

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(X_W)
  ) u_h (
    .i_clk(inputclock), .i_rst(input_reset), .i_en(pixel), .i_clr(input_restart),
    .o_cnt(output_x), .o_tc(w_h_tc), .o_sync(output_hsync), .o_nxt_active(w_h_nxt_act)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(Y_W)
  ) u_v (
    .i_clk(inputclock), .i_rst(input_reset), .i_en(w_v_en), .i_clr(input_restart),
    .o_cnt(output_y), .o_tc(w_v_tc), .o_sync(output_vsync), .o_nxt_active(w_v_nxt_act)
  );

  // Active-video flag registered from both axes' next-state counts
  always_ff @(posedge inputclock or posedge input_reset) begin
    if (input_reset) r_active <= 1'b1;
    else             r_active <= w_h_nxt_act & w_v_nxt_act;
  end

  assign output_active    = r_active;
  assign output_line_end  = pixel & w_h_tc;
  assign output_frame_end = output_line_end & w_v_tc;

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [FRAME_CNT_W-1:0] r_frame_count;

  // Completed-frame counter; survives restart, cleared only by reset
  always_ff @(posedge inputclock or posedge input_reset) begin
    if (input_reset)           r_frame_count <= '0;
    else if (output_frame_end) r_frame_count <= r_frame_count + 1'b1;
  end

  assign output_frame_count = r_frame_count;
`else
  assign output_frame_count = '0;
`endif

endmodule
